// File: rtl/uart_pkg.sv
// Shared types and tick constants for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchroniser (STAGES >= 2) preset to RESET_VAL, with an optional registered rising-edge pulse.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter bit   EDGE_EN   = 1'b1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic Sys_clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge Sys_clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;
            logic rise_q;
            // Previous value is preset like the chain so reset never fakes an edge.
            always_ff @(posedge Sys_clk or negedge reset) begin
                if (!reset) begin
                    prev_q <= RESET_VAL;
                    rise_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[STAGES-1];
                    rise_q <= sync_q[STAGES-1] & ~prev_q;
                end
            end
            assign rise_o = rise_q;
        end else begin : g_no_edge
            assign rise_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver clocked by Sys_clk and stepped by ticks derived from clk16.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Sys_clk,
    input  logic              reset,
    input  logic              clk16,
    input  logic              rx,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_par_err,
    output logic              rx_overrun,
    output logic              rx_busy,
    output rx_state_t         rx_state_o
);

    localparam logic [3:0] LAST_T = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    logic tick, rx_s, clk16_s_unused, rx_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1), .RESET_VAL(1'b1)) u_clk16_sync (
        .Sys_clk (Sys_clk),
        .reset   (reset),
        .d_i     (clk16),
        .q_o     (clk16_s_unused),
        .rise_o  (tick)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0), .RESET_VAL(1'b1)) u_rx_sync (
        .Sys_clk (Sys_clk),
        .reset   (reset),
        .d_i     (rx),
        .q_o     (rx_s),
        .rise_o  (rx_rise_unused)
    );

    rx_state_t         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        bitn_q, bitn_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              done;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge Sys_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bitn_d  = bitn_q;
        shreg_d = shreg_q;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        state_d = START;
                    end
                end
                START: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == MID_TICK) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d   = '0;
                            bitn_d  = '0;
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_T) begin
                        shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
                        if (bitn_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bitn_d = bitn_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_T) begin
                        par_d   = rx_s;
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_T) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake: rx_valid is a level held until rx_ack (one-cycle pulse) clears it on the
    // next edge; a completing frame always wins over a same-cycle ack, and overruns only
    // when it lands on an unacknowledged byte.
    logic [DATA_W-1:0] data_q;
    logic              valid_q, ferr_q, ovr_q;

    always_ff @(posedge Sys_clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (done) begin
                data_q  <= shreg_q;
                ferr_q  <= ~rx_s;
                valid_q <= 1'b1;
            end else if (rx_ack) begin
                valid_q <= 1'b0;
            end
            ovr_q <= (ovr_q | (done & valid_q)) & ~rx_ack;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_q;
    always_ff @(posedge Sys_clk or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else if (done) begin
            perr_q <= (^shreg_q) ^ par_q;
        end
    end
    assign rx_par_err = perr_q;
`else
    assign rx_par_err = 1'b0;
`endif

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = (state_q != IDLE);
    assign rx_state_o   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean byte, false start, framing error, overrun, reset mid-frame, parity.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int TICK_T = 80;
    localparam int BIT_T  = 16 * TICK_T;

    logic       Sys_clk = 1'b0;
    logic       clk16   = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic       rx_ack  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_par_err, rx_overrun, rx_busy;
    rx_state_t  rx_state_o;

    int checks = 0;
    int errors = 0;
`ifdef UART_RX_PARITY_EN
    logic tx_par_flip = 1'b0;
`endif

    uart_rx dut (
        .Sys_clk      (Sys_clk),
        .reset        (reset),
        .clk16        (clk16),
        .rx           (rx),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_par_err   (rx_par_err),
        .rx_overrun   (rx_overrun),
        .rx_busy      (rx_busy),
        .rx_state_o   (rx_state_o)
    );

    always #5 Sys_clk = ~Sys_clk;
    always #(TICK_T / 2) clk16 = ~clk16;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one frame, then watches (bounded) for rx_busy to drop at the stop sample.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input string tag,
                              output logic prev_valid);
        logic seen;
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(BIT_T);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^data) ^ tx_par_flip;
        #(BIT_T);
`endif
        rx = stop_bit;
        seen = 1'b0;
        prev_valid = rx_valid;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge Sys_clk);
            if (!rx_busy) seen = 1'b1;
            else prev_valid = rx_valid;
        end
        check({tag, " frame done"}, 32'(seen), 32'd1);
        check({tag, " valid with busy fall"}, 32'(rx_valid), 32'd1);
        rx = 1'b1;
        #(BIT_T);
    endtask

    task automatic pulse_ack();
        @(negedge Sys_clk);
        rx_ack = 1'b1;
        @(negedge Sys_clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        logic pv;

        // Reset state
        #2 reset = 1'b0;
        repeat (5) @(negedge Sys_clk);
        check("rst data", 32'(rx_data), 32'h0);
        check("rst valid", 32'(rx_valid), 32'd0);
        check("rst frame_err", 32'(rx_frame_err), 32'd0);
        check("rst par_err", 32'(rx_par_err), 32'd0);
        check("rst overrun", 32'(rx_overrun), 32'd0);
        check("rst busy", 32'(rx_busy), 32'd0);
        check("rst state", 32'(rx_state_o), 32'(IDLE));
        reset = 1'b1;
        #(BIT_T);

        // Clean byte 0xA5
        send_frame(8'hA5, 1'b1, "A5", pv);
        check("A5 valid before done", 32'(pv), 32'd0);
        check("A5 data", 32'(rx_data), 32'hA5);
        check("A5 frame_err", 32'(rx_frame_err), 32'd0);
        check("A5 par_err", 32'(rx_par_err), 32'd0);
        check("A5 overrun", 32'(rx_overrun), 32'd0);
        pulse_ack();
        check("A5 ack valid", 32'(rx_valid), 32'd0);

        // False start: low for 4 ticks
        @(negedge Sys_clk);
        rx = 1'b0;
        #(2 * TICK_T);
        check("false start busy", 32'(rx_busy), 32'd1);
        #(2 * TICK_T);
        rx = 1'b1;
        #(8 * TICK_T);
        check("false start idle busy", 32'(rx_busy), 32'd0);
        check("false start state", 32'(rx_state_o), 32'(IDLE));
        check("false start valid", 32'(rx_valid), 32'd0);
        #(BIT_T);

        // Framing error on 0x3C
        send_frame(8'h3C, 1'b0, "3C", pv);
        check("3C data", 32'(rx_data), 32'h3C);
        check("3C frame_err", 32'(rx_frame_err), 32'd1);
        pulse_ack();

        // Overrun: 0x11 then 0x22 without ack
        send_frame(8'h11, 1'b1, "11", pv);
        check("11 data", 32'(rx_data), 32'h11);
        check("11 frame_err", 32'(rx_frame_err), 32'd0);
        check("11 overrun", 32'(rx_overrun), 32'd0);
        send_frame(8'h22, 1'b1, "22", pv);
        check("22 data", 32'(rx_data), 32'h22);
        check("22 overrun", 32'(rx_overrun), 32'd1);
        pulse_ack();
        check("ovr ack valid", 32'(rx_valid), 32'd0);
        check("ovr ack overrun", 32'(rx_overrun), 32'd0);

        // Unacked byte, then reset during data bit 3
        send_frame(8'h96, 1'b1, "96", pv);
        check("96 data", 32'(rx_data), 32'h96);
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h96 >> i);
            #(BIT_T);
        end
        rx = 1'b0;
        #(BIT_T / 2);
        @(negedge Sys_clk);
        check("mid busy", 32'(rx_busy), 32'd1);
        check("mid state", 32'(rx_state_o), 32'(DATA));
        #1 reset = 1'b0;
        #1;
        check("mid rst data", 32'(rx_data), 32'h0);
        check("mid rst valid", 32'(rx_valid), 32'd0);
        check("mid rst busy", 32'(rx_busy), 32'd0);
        check("mid rst frame_err", 32'(rx_frame_err), 32'd0);
        rx = 1'b1;
        #20 reset = 1'b1;
        #(BIT_T);
        send_frame(8'h5A, 1'b1, "5A", pv);
        check("5A valid before done", 32'(pv), 32'd0);
        check("5A data", 32'(rx_data), 32'h5A);
        check("5A frame_err", 32'(rx_frame_err), 32'd0);
        pulse_ack();

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: parity bit 0 is wrong, 1 is right
        tx_par_flip = 1'b1;
        send_frame(8'h07, 1'b1, "07p0", pv);
        check("07p0 data", 32'(rx_data), 32'h07);
        check("07p0 par_err", 32'(rx_par_err), 32'd1);
        pulse_ack();
        tx_par_flip = 1'b0;
        send_frame(8'h07, 1'b1, "07p1", pv);
        check("07p1 par_err", 32'(rx_par_err), 32'd0);
        pulse_ack();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver sitting directly downstream of the baud-rate generator. It consumes the generator's 16× oversample clock `clk16` as a sampling strobe, not as a clock. It deserialises the asynchronous `rx` line (8N1, LSB first) in the `Sys_clk` domain and presents each byte with a valid/ack handshake plus framing and overrun status. Its consumer is the processor's UART peripheral register block.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame.
- `OVERSAMPLE`, 16: `clk16` rising edges per bit.
- `SYNC_STAGES`, 2: synchroniser depth applied to both `rx` and `clk16`.

Ports:
- `Sys_clk`, in, 1: system clock.
- `reset`, in, 1: reset, asynchronous, active-low. Clock is `Sys_clk`.
- `clk16`, in, 1: oversample square wave from the baud-rate generator.
- `rx`, in, 1: serial line; idles high.
- `rx_ack`, in, 1: one-cycle pulse; consumer has taken `rx_data`.
- `rx_data`, out, `DATA_W`: last received byte.
- `rx_valid`, out, 1: byte pending; level signal.
- `rx_frame_err`, out, 1: stop bit of the current `rx_data` sampled low.
- `rx_par_err`, out, 1: parity mismatch on the current `rx_data`; driven 0 when parity is not compiled in.
- `rx_overrun`, out, 1: sticky; a byte was lost.
- `rx_busy`, out, 1: high in any state other than IDLE.

## Operation
- **Synchronisation:** `clk16` and `rx` each pass through `SYNC_STAGES` flops.
  - `tick` is a one-`Sys_clk` pulse on the rising edge of the synchronised `clk16`.
  - All FSM activity advances on `tick` only.
- **Counters:** `cnt` is 4 bits and counts ticks within a bit. `bitn` is 3 bits and indexes the data bit.
- **FSM states and transitions:**
  - **IDLE:** on `tick` with `rx_s==0`, set `cnt=0` and go to START.
  - **START:** on each `tick`, `cnt++`.
    - At `cnt==7` (mid start bit), if `rx_s==1` it is a false start: go to IDLE.
    - Otherwise set `cnt=0` and `bitn=0`, then go to DATA.
  - **DATA:** on each `tick`, `cnt++`.
    - At `cnt==15`, shift `rx_s` into `shreg` at the MSB (LSB-first reception) and let `cnt` wrap to 0.
    - When `bitn==DATA_W-1`, go to PARITY or STOP. Otherwise `bitn++`.
  - **PARITY** (macro only): at `cnt==15`, capture the parity bit and go to STOP.
  - **STOP:** at `cnt==15`, sample the stop bit, then:
    - load `rx_data` from `shreg`;
    - set `rx_frame_err` to the inverse of the stop bit;
    - set `rx_par_err`;
    - set `rx_valid`;
    - go to IDLE.
    - A low stop bit still delivers the byte. A held break yields repeated 0x00 bytes, each with a framing error.
- **Handshake:**
  - `rx_ack` clears `rx_valid` and `rx_overrun` on the next edge.
  - A frame completing while `rx_valid==1` and `rx_ack==0` overwrites `rx_data` and sets `rx_overrun`.
  - Completion and `rx_ack` in the same cycle: the new byte wins, `rx_valid` stays 1, and `rx_overrun` is not set.
- **Reset values:** all outputs 0; FSM in IDLE; counters 0; synchronisers preset to 1 (line idle).

## Timing
- `rx` edge to visibility in the FSM: `SYNC_STAGES` cycles. `tick` lags the `clk16` rising edge by `SYNC_STAGES`+1 cycles.
- Outputs update 1 `Sys_clk` after the stop-sample `tick`.
- With a 100 MHz `Sys_clk` and `clk16` period 328 cycles: 1 bit = 5248 cycles, and an 8N1 frame reaches `rx_valid` about 9.5 bits after the start edge.
- Sampling is at tick 8 of the start bit, then every 16 ticks. This tolerates roughly ±3% baud mismatch.
- Reset mid-frame aborts it immediately. Nothing is delivered. Reception resumes at the next falling edge seen in IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in; the frame is 8E1.
  - `rx_par_err` is set to (XOR of data bits XOR parity bit).
- Not defined:
  - PARITY state is absent; the frame is 8N1.
  - `rx_par_err` is tied to 0.

## Structure
- Package `uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `MID_TICK=7` and `LAST_TICK=15`.
- Sub-module `sync_edge`: an N-stage synchroniser with an optional rising-edge pulse output. Instantiate it once for `clk16` (edge output used) and once for `rx` (level output only).

## Test plan
- **Clean byte:** send 0xA5 as 8N1 at nominal baud → `rx_data`=0xA5, `rx_valid`=1, `rx_frame_err`=0, `rx_busy` falls in the same cycle.
- **False start:** drive `rx` low for 4 ticks, then high → no `rx_valid`; FSM back in IDLE; `rx_busy`=0 by tick 8.
- **Framing error:** send 0x3C with stop bit 0 → `rx_data`=0x3C, `rx_valid`=1, `rx_frame_err`=1.
- **Overrun:** send 0x11 then 0x22 with no ack → `rx_data`=0x22, `rx_overrun`=1. Pulse `rx_ack` → `rx_valid`=0 and `rx_overrun`=0 next cycle.
- **Reset mid-frame:** assert `reset` during DATA bit 3 → all outputs 0 immediately. Then send 0x5A → received correctly.
- **Parity** (`UART_RX_PARITY_EN`): send 0x07 with parity bit 0 → `rx_par_err`=1. Send 0x07 with parity bit 1 → `rx_par_err`=0.
